// File: rtl/dds_voice_engine.sv
`default_nettype none
// ============================================================================
// dds_voice_engine : time-multiplexed multi-voice DDS with SPI command parser
// Revision 1.0
// ============================================================================
module dds_voice_engine #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int FREQ_W     = 16,
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 24,
  parameter int OUT_W      = 8,
  parameter int DIV        = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        rom_wave,
  input  logic [DATA_W-1:0] rom_data,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sample_valid,
  output logic              cmd_error
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = DATA_W + VIDX_W;
  localparam int CNT_W  = $clog2(DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [1:0] P_CMD   = 2'd0;
  localparam logic [1:0] P_VOICE = 2'd1;
  localparam logic [1:0] P_PAY0  = 2'd2;
  localparam logic [1:0] P_PAY1  = 2'd3;

  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [FREQ_W-1:0]  r_tune  [NUM_VOICES];
  logic [7:0]         r_env   [NUM_VOICES];
  logic [2:0]         r_wave  [NUM_VOICES];

  logic [CNT_W-1:0]   r_cnt;
  logic               w_tick;

  logic [1:0]         r_pstate;
  logic [1:0]         r_cmd;
  logic [VIDX_W-1:0]  r_voice;
  logic               r_vbad;
  logic [7:0]         r_hi;
  logic               r_cmd_error;
  logic               w_voice_ok;

  logic [1:0]         r_mstate;
  logic [VIDX_W-1:0]  r_k;
  logic               r_pv;
  logic [7:0]         r_penv;
  logic [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_sample;
  logic               r_valid;
  logic [DATA_W+7:0]  w_prod;
  logic [DATA_W-1:0]  w_term;

  assign w_tick     = (r_cnt == CNT_W'(DIV - 1));
  assign w_voice_ok = (rx_data < 8'(NUM_VOICES));
  assign w_prod     = {8'd0, rom_data} * {{DATA_W{1'b0}}, r_penv};
  assign w_term     = w_prod[DATA_W+7:8];

  assign rom_addr     = (r_mstate == S_FETCH) ? r_phase[r_k][PHASE_W-1 -: ADDR_W] : '0;
  assign rom_wave     = (r_mstate == S_FETCH) ? r_wave[r_k] : 3'd0;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign cmd_error    = r_cmd_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        for (int v = 0; v < NUM_VOICES; v++)
          r_phase[v] <= r_phase[v] + PHASE_W'(r_tune[v]);
      end
    end
  end

  // Writes land only on the frame's final byte, so a truncated frame is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pstate    <= P_CMD;
      r_cmd       <= 2'd0;
      r_voice     <= '0;
      r_vbad      <= 1'b0;
      r_hi        <= 8'd0;
      r_cmd_error <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_tune[v] <= '0;
        r_env[v]  <= 8'd0;
        r_wave[v] <= 3'd0;
      end
    end else begin
      r_cmd_error <= 1'b0;
      if (frame_start) begin
        r_pstate <= P_CMD;
      end else if (rx_valid) begin
        case (r_pstate)
          P_CMD: begin
            if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) begin
              r_cmd    <= rx_data[1:0];
              r_pstate <= P_VOICE;
            end else begin
              r_cmd_error <= 1'b1;
            end
          end
          P_VOICE: begin
            r_voice     <= rx_data[VIDX_W-1:0];
            r_vbad      <= !w_voice_ok;
            r_cmd_error <= !w_voice_ok;
            r_pstate    <= P_PAY0;
          end
          P_PAY0: begin
            if (r_cmd == 2'd1) begin
              r_hi     <= rx_data;
              r_pstate <= P_PAY1;
            end else begin
              if (!r_vbad) begin
                if (r_cmd == 2'd2) r_env[r_voice]  <= rx_data;
                else               r_wave[r_voice] <= rx_data[2:0];
              end
              r_pstate <= P_CMD;
            end
          end
          default: begin
            if (!r_vbad) r_tune[r_voice] <= FREQ_W'({r_hi, rx_data});
            r_pstate <= P_CMD;
          end
        endcase
      end
    end
  end

  // Envelope is latched at fetch time so a later write only affects the next sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstate <= S_IDLE;
      r_k      <= '0;
      r_pv     <= 1'b0;
      r_penv   <= 8'd0;
      r_acc    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_mstate)
        S_IDLE: begin
          if (w_tick) begin
            r_mstate <= S_FETCH;
            r_k      <= '0;
            r_pv     <= 1'b0;
            r_acc    <= '0;
          end
        end
        S_FETCH: begin
          if (r_pv) r_acc <= r_acc + ACC_W'(w_term);
          r_pv   <= 1'b1;
          r_penv <= r_env[r_k];
          r_k    <= r_k + 1'b1;
          if (r_k == VIDX_W'(NUM_VOICES - 1)) r_mstate <= S_DRAIN;
        end
        S_DRAIN: begin
          r_acc    <= r_acc + ACC_W'(w_term);
          r_pv     <= 1'b0;
          r_mstate <= S_OUT;
        end
        default: begin
          r_sample <= r_acc[ACC_W-1 -: OUT_W];
          r_valid  <= 1'b1;
          r_mstate <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_engine.sv
`default_nettype none
// ============================================================================
// tb_dds_voice_engine : directed self-checking bench for dds_voice_engine
// Revision 1.0
// ============================================================================
module tb_dds_voice_engine;

  localparam int N   = 8;
  localparam int DIV = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        frame_start;
  logic [21:0] rom_addr;
  logic [2:0]  rom_wave;
  logic [23:0] rom_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        cmd_error;

  logic        rom_mode;
  logic [21:0] h_addr [16];
  logic [2:0]  h_wave [16];
  int          ncyc;
  int          nvec;
  int          nfail;
  logic        err;
  logic        ok;

  dds_voice_engine #(.NUM_VOICES(N), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_start(frame_start), .rom_addr(rom_addr), .rom_wave(rom_wave),
    .rom_data(rom_data), .sample_out(sample_out), .sample_valid(sample_valid),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Synchronous wavetable: mode 0 returns addr<<2, mode 1 returns full scale.
  always @(posedge clk) rom_data <= rom_mode ? 24'hFFFFFF : {rom_addr, 2'b00};

  task automatic step();
    @(negedge clk);
    for (int i = 15; i > 0; i--) begin
      h_addr[i] = h_addr[i-1];
      h_wave[i] = h_wave[i-1];
    end
    h_addr[0] = rom_addr;
    h_wave[0] = rom_wave;
    ncyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output logic e);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    e = cmd_error;
  endtask

  task automatic wait_valid(output logic found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (sample_valid === 1'b1) found = 1'b1;
    end
    check("valid_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; frame_start = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    ncyc  = 0;
  endtask

  // Fetch of voice k happens N+2-k cycles before the sample_valid cycle.
  function automatic logic [21:0] vaddr(input int k);
    return h_addr[N + 2 - k];
  endfunction
  function automatic logic [2:0] vwave(input int k);
    return h_wave[N + 2 - k];
  endfunction

  initial begin
    nvec = 0; nfail = 0; rom_mode = 1'b0; ncyc = 0;
    for (int i = 0; i < 16; i++) begin h_addr[i] = '0; h_wave[i] = '0; end

    // Reset state and free-running sample cadence
    do_reset();
    check("rst_sample_out", {24'd0, sample_out}, 32'd0);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
    check("rst_rom_addr", {10'd0, rom_addr}, 32'd0);
    check("rst_rom_wave", {29'd0, rom_wave}, 32'd0);
    wait_valid(ok);
    check("first_valid_cycle", ncyc, DIV + N + 2);
    check("idle_sample_out", {24'd0, sample_out}, 32'd0);
    for (int k = 0; k < N; k++) check("idle_addr", {10'd0, vaddr(k)}, 32'd0);
    wait_valid(ok);
    check("second_valid_cycle", ncyc, 2 * DIV + N + 2);

    // Voice 0 tuned to 0x0400: address steps by one per tick
    do_reset();
    rom_mode = 1'b0;
    send(8'h01, err); send(8'h00, err); send(8'h04, err); send(8'h00, err);
    send(8'h02, err); send(8'h00, err); send(8'hFF, err);
    wait_valid(ok);
    check("v0_addr_t1", {10'd0, vaddr(0)}, 32'd1);
    check("v1_addr_t1", {10'd0, vaddr(1)}, 32'd0);
    check("v7_addr_t1", {10'd0, vaddr(7)}, 32'd0);
    check("v0_wave", {29'd0, vwave(0)}, 32'd0);
    check("v0_small_mix", {24'd0, sample_out}, 32'd0);
    wait_valid(ok);
    check("v0_addr_t2", {10'd0, vaddr(0)}, 32'd2);

    // Wave select and envelope scaling with full-scale table data
    do_reset();
    rom_mode = 1'b1;
    send(8'h03, err); send(8'h02, err); send(8'h04, err);
    send(8'h02, err); send(8'h02, err); send(8'h80, err);
    wait_valid(ok);
    check("v2_wave", {29'd0, vwave(2)}, 32'd4);
    check("v1_wave", {29'd0, vwave(1)}, 32'd0);
    check("v2_half_mix", {24'd0, sample_out}, 32'h0F);
    send(8'h02, err); send(8'h03, err); send(8'hFF, err);
    wait_valid(ok);
    check("v2v3_mix", {24'd0, sample_out}, 32'h2F);

    // Unknown command and out-of-range voice
    do_reset();
    rom_mode = 1'b1;
    send(8'h05, err); check("err_cmd05", {31'd0, err}, 32'd1);
    send(8'h01, err); check("err_cmd01", {31'd0, err}, 32'd0);
    send(8'h09, err); check("err_voice09", {31'd0, err}, 32'd1);
    send(8'h12, err); check("err_hi", {31'd0, err}, 32'd0);
    send(8'h34, err); check("err_lo", {31'd0, err}, 32'd0);
    send(8'h02, err); check("err_env_cmd", {31'd0, err}, 32'd0);
    send(8'h01, err); check("err_env_voice", {31'd0, err}, 32'd0);
    send(8'h10, err); check("err_env_lvl", {31'd0, err}, 32'd0);
    wait_valid(ok);
    check("env1_mix", {24'd0, sample_out}, 32'h01);
    for (int k = 0; k < N; k++) check("bad_voice_no_tune", {10'd0, vaddr(k)}, 32'd0);

    // frame_start discards a partial frame and wins over a same-cycle byte
    do_reset();
    rom_mode = 1'b0;
    send(8'h01, err); send(8'h03, err); send(8'h12, err);
    frame_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    step();
    frame_start = 1'b0; rx_valid = 1'b0;
    send(8'h01, err); send(8'h03, err); send(8'h00, err); send(8'h10, err);
    wait_valid(ok);
    check("v3_addr_s1", {10'd0, vaddr(3)}, 32'd0);
    for (int s = 2; s < 64; s++) wait_valid(ok);
    check("v3_addr_s63", {10'd0, vaddr(3)}, 32'd0);
    wait_valid(ok);
    check("v3_addr_s64", {10'd0, vaddr(3)}, 32'd1);

    // Tuning commit coincident with a tick applies from the next tick
    do_reset();
    rom_mode = 1'b0;
    send(8'h01, err); send(8'h00, err); send(8'h04, err); send(8'h00, err);
    send(8'h01, err); send(8'h00, err); send(8'h08, err);
    while (ncyc < DIV - 1) step();
    send(8'h00, err);
    wait_valid(ok);
    check("tick_commit_old", {10'd0, vaddr(0)}, 32'd1);
    wait_valid(ok);
    check("tick_commit_new", {10'd0, vaddr(0)}, 32'd3);

    // Reset in the middle of a mix suppresses that sample
    do_reset();
    while (ncyc < DIV + 4) step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    ncyc  = 0;
    check("midmix_rst_valid", {31'd0, sample_valid}, 32'd0);
    wait_valid(ok);
    check("midmix_rst_next_valid", ncyc, DIV + N + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_voice_engine.md
Name: dds_voice_engine

Overview:
- Multi-voice, time-multiplexed DDS core; successor to the single-voice oscillator.
- Holds NUM_VOICES phase accumulators plus per-voice tuning word, envelope level and waveform select, all loaded from the SPI slave's received-byte stream via a framed command parser.
- Once per sample tick, fetches one wavetable word per voice through a shared synchronous ROM port, scales by envelope, mixes, and presents one unsigned sample to the R2R DAC driver.

Parameters:
NUM_VOICES, 8, voice count (power of 2, 2..16)
PHASE_W, 32, phase accumulator / tuning word width
FREQ_W, 16, tuning word width loaded over SPI (zero-extended to PHASE_W)
ADDR_W, 22, wavetable address width (address = phase[PHASE_W-1 -: ADDR_W])
DATA_W, 24, wavetable word width (unsigned)
OUT_W, 8, output sample width
DIV, 500, clocks per sample tick (must be >= NUM_VOICES+4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received SPI byte
rx_data  in  8  received SPI byte
frame_start  in  1  one-cycle strobe on nss falling edge; resynchronises parser
rom_addr  out  ADDR_W  shared wavetable address
rom_wave  out  3  waveform table select for rom_addr (0 sine, 1 pos saw, 2 neg saw, 3 tri, 4 square)
rom_data  in  DATA_W  wavetable word, valid exactly 1 clk after rom_addr/rom_wave
sample_out  out  OUT_W  mixed sample, held between updates
sample_valid  out  1  one-cycle strobe when sample_out updates
cmd_error  out  1  one-cycle strobe on unknown command byte or out-of-range voice index

Behaviour:
- Reset: all phases, tuning words, envelopes = 0; all wave selects = 0; sample_out = 0; sample_valid = 0; cmd_error = 0; rom_addr = 0; rom_wave = 0; tick counter = 0; parser in CMD; mixer in IDLE.
- Tick counter: counts 0..DIV-1 and wraps. tick asserted for one clk when count == DIV-1.
- On tick: every phase[v] <= phase[v] + tuning[v] (mod 2^PHASE_W), in the same clk. Tuning words are the values registered before that edge.
- Mixer FSM: IDLE -> FETCH (NUM_VOICES clks) -> DRAIN (1 clk) -> OUT (1 clk) -> IDLE.
  - FETCH starts the clk after tick. In FETCH cycle k it drives rom_addr = phase[k] top ADDR_W bits and rom_wave = wave[k].
  - From FETCH cycle 1 through DRAIN, acc += (rom_data * env[k-1]) >> 8, where env is 8-bit and 255 ≈ unity.
  - acc is DATA_W + log2(NUM_VOICES) bits, cleared on entry to FETCH.
  - OUT: sample_out <= acc[MSB -: OUT_W]; sample_valid = 1.
  - Latency tick -> sample_valid = NUM_VOICES+3 clks.
  - A tick while not IDLE cannot occur under the DIV constraint; it is not required to be handled.
- Parser FSM: CMD -> VOICE -> PAY0 -> PAY1. Advances only on rx_valid.
  - CMD byte 0x01 = frequency: voice, hi, lo.
  - CMD byte 0x02 = envelope: voice, level.
  - CMD byte 0x03 = wave select: voice, sel[2:0].
  - Any other byte in CMD: cmd_error pulse, stay in CMD.
  - Voice index >= NUM_VOICES: cmd_error pulse on that byte. The remaining payload bytes are consumed with no write.
  - Write commits on the final byte's clk: tuning[v] = {hi,lo}. A partially received frame never alters state.
  - A commit in the same clk as tick is not seen by that tick's phase update; it applies from the next tick.
  - A commit during FETCH of env/wave for a voice already fetched affects the next sample only.
  - Wave sel > 4 is stored as is; the ROM mux defines the output for it.
- frame_start returns the parser to CMD and discards any partial frame.
  - frame_start takes priority over rx_valid in the same clk; that rx_valid byte is dropped.
- Reset mid-frame or mid-mix: immediate return to reset state; no sample_valid for the aborted sample.

Test Plan:
- Reset, no commands -> sample_valid pulses every DIV clks, first pulse NUM_VOICES+3 clks after first tick; sample_out = 0; all rom_addr = 0.
- Bytes 01 00 04 00, then 02 00 FF, with ROM model returning rom_data = addr<<2 -> phase[0] += 0x400 per tick; rom_addr for voice 0 advances by 1 per tick (0x400 >> 10); other voices stay at 0.
- Bytes 03 02 04 then 02 02 80 -> voice 2 fetch drives rom_wave = 4; with constant rom_data = 0xFFFFFF, voice 2 contributes 0x7FFFFF; sample_out = 0x0F (8-voice mix).
- Bytes 05, then 01 09 12 34 with NUM_VOICES=8 -> cmd_error on 05 and on 09; no tuning word changes; the next frame 02 01 10 is accepted.
- Bytes 01 03 12 then frame_start then 01 03 00 10 -> tuning[3] = 0x0010, never 0x12xx.
- Final frequency byte rx_valid in the same clk as tick -> that tick adds the old tuning word; the following tick adds the new one.
